// File: rtl/if_id_fetch_stage_if.sv
// Instruction-memory read port between the fetch stage and instruction memory.
//   imem_req   : fetch request (fetch stage -> memory)
//   imem_addr  : word-aligned fetch address (fetch stage -> memory)
//   imem_rdata : fetched word, valid when imem_ready (memory -> fetch stage)
//   imem_ready : read completes this cycle (memory -> fetch stage)
interface if_id_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );
endinterface

// File: rtl/if_id_fetch_stage.sv
// Instruction fetch stage plus IF/ID pipeline register.
// Holds the PC, issues word reads over the imem interface, buffers one returned
// word in a skid register across decode stalls, and redirects on jump/branch.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   stall                 : decode stalled, IF/ID holds
//   jump, jump_index      : jump resolved in ID and its instr[25:0]
//   branch_taken, branch_imm : taken branch and its signed word offset
//   imem (master)         : imem_req/imem_addr out, imem_rdata/imem_ready in
//   if_id_instr/pc4/valid : IF/ID register contents
//   opcode                : if_id_instr[31:26] to Control (combinational)
//   perf_fetched/bubbles  : performance counters
// Optional feature macro: IF_PERF_CNT_EN (counters present when defined,
// otherwise both perf outputs are tied to zero).
module if_id_fetch_stage #(
    parameter logic [31:0] PC_RESET      = 32'h0000_0000,
    parameter int unsigned SKID_EN_DEPTH = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       stall,
    input  logic                       jump,
    input  logic [25:0]                jump_index,
    input  logic                       branch_taken,
    input  logic [15:0]                branch_imm,
    if_id_fetch_stage_if.master        imem,
    output logic [31:0]                if_id_instr,
    output logic [31:0]                if_id_pc4,
    output logic                       if_id_valid,
    output logic [5:0]                 opcode,
    output logic [31:0]                perf_fetched,
    output logic [31:0]                perf_bubbles
);

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    // Only a single-entry skid register is implemented.
    if (SKID_EN_DEPTH != 1) begin : g_bad_skid_depth
        $error("if_id_fetch_stage: SKID_EN_DEPTH must be 1");
    end

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc4_q, pc4_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] skid_instr_q, skid_instr_d;
    logic [XLEN-1:0] skid_pc4_q, skid_pc4_d;

    logic            redirect_c;
    logic [XLEN-1:0] jump_target_c;
    logic [XLEN-1:0] branch_target_c;

    // Redirect only counts when ID actually holds an instruction.
    assign redirect_c      = valid_q & (jump | branch_taken);
    assign jump_target_c   = {pc4_q[31:28], jump_index, 2'b00};
    assign branch_target_c = pc4_q + XLEN'({{14{branch_imm[15]}}, branch_imm, 2'b00});

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and datapath next values.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        valid_d      = valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;

        if (redirect_c) begin
            // Flush everything in flight; any word returning now is dropped.
            pc_d         = jump ? jump_target_c : branch_target_c;
            instr_d      = '0;
            valid_d      = 1'b0;
            skid_instr_d = '0;
            skid_pc4_d   = '0;
            state_d      = ST_FETCH;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_FETCH;
                ST_FETCH: begin
                    if (imem.imem_ready) begin
                        pc_d = pc_q + XLEN'(4);
                        if (!stall) begin
                            instr_d = imem.imem_rdata;
                            pc4_d   = pc_q + XLEN'(4);
                            valid_d = 1'b1;
                        end else begin
                            skid_instr_d = imem.imem_rdata;
                            skid_pc4_d   = pc_q + XLEN'(4);
                            state_d      = ST_SKID;
                        end
                    end else if (!stall) begin
                        instr_d = '0;
                        valid_d = 1'b0;
                    end
                end
                ST_SKID: begin
                    if (!stall) begin
                        instr_d      = skid_instr_q;
                        pc4_d        = skid_pc4_q;
                        valid_d      = 1'b1;
                        skid_instr_d = '0;
                        skid_pc4_d   = '0;
                        state_d      = ST_FETCH;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // PC, IF/ID and skid registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= PC_RESET;
            instr_q      <= '0;
            pc4_q        <= '0;
            valid_q      <= 1'b0;
            skid_instr_q <= '0;
            skid_pc4_q   <= '0;
        end else begin
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
        end
    end

    assign imem.imem_req  = (state_q == ST_FETCH);
    assign imem.imem_addr = pc_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc4      = pc4_q;
    assign if_id_valid    = valid_q;
    assign opcode         = instr_q[31:26];

`ifdef IF_PERF_CNT_EN
    logic [XLEN-1:0] fetched_q, bubbles_q;
    logic            fetched_inc_c, bubble_inc_c;

    // Classify what IF/ID loads this cycle: a real instruction or a bubble.
    always_comb begin
        fetched_inc_c = 1'b0;
        bubble_inc_c  = 1'b0;
        if (redirect_c) begin
            bubble_inc_c = 1'b1;
        end else if (!stall) begin
            if (state_q == ST_FETCH) begin
                fetched_inc_c = imem.imem_ready;
                bubble_inc_c  = ~imem.imem_ready;
            end else if (state_q == ST_SKID) begin
                fetched_inc_c = 1'b1;
            end
        end
    end

    // Wrapping event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q <= '0;
            bubbles_q <= '0;
        end else begin
            if (fetched_inc_c) fetched_q <= fetched_q + XLEN'(1);
            if (bubble_inc_c)  bubbles_q <= bubbles_q + XLEN'(1);
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_bubbles = bubbles_q;
`else
    assign perf_fetched = '0;
    assign perf_bubbles = '0;
`endif

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Self-checking bench for if_id_fetch_stage: directed scenarios followed by
// randomized traffic, all compared against a behavioural pipeline model.
module tb_if_id_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        jump = 1'b0;
    logic [25:0] jump_index = '0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_imm = '0;
    logic [31:0] if_id_instr, if_id_pc4, perf_fetched, perf_bubbles;
    logic        if_id_valid;
    logic [5:0]  opcode;

    if_id_fetch_stage_if imem ();

    if_id_fetch_stage #(.PC_RESET(32'h0000_0000), .SKID_EN_DEPTH(1)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .jump(jump),
        .jump_index(jump_index), .branch_taken(branch_taken),
        .branch_imm(branch_imm), .imem(imem.master),
        .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
        .if_id_valid(if_id_valid), .opcode(opcode),
        .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Behavioural model: a pending-word queue (at most one entry) stands in for the skid.
    typedef struct { logic [31:0] instr; logic [31:0] pc4; } entry_t;
    entry_t      skid_q[$];
    logic        m_started;
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;
    logic [31:0] m_fetched, m_bubbles;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h8C08_0000;
        if (a == 32'h4) return 32'hAC09_0004;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    endtask

    task automatic model_reset();
        skid_q.delete();
        m_started = 1'b0;
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        m_fetched = 32'h0; m_bubbles = 32'h0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        logic [31:0] tgt;
        if (!m_started) begin
            m_started = 1'b1;
        end else if (m_valid && (jump || branch_taken)) begin
            if (jump) tgt = {m_pc4[31:28], jump_index, 2'b00};
            else      tgt = m_pc4 + 32'($signed(branch_imm)) * 32'd4;
            m_pc = tgt; m_instr = 32'h0; m_valid = 1'b0;
            skid_q.delete();
            m_bubbles++;
        end else if (skid_q.size() > 0) begin
            if (!stall) begin
                m_instr = skid_q[0].instr; m_pc4 = skid_q[0].pc4; m_valid = 1'b1;
                void'(skid_q.pop_front());
                m_fetched++;
            end
        end else if (imem.imem_ready && !stall) begin
            m_instr = mem_word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
            m_fetched++;
        end else if (!imem.imem_ready && !stall) begin
            m_instr = 32'h0; m_valid = 1'b0;
            m_bubbles++;
        end else if (imem.imem_ready && stall) begin
            skid_q.push_back('{instr: mem_word(m_pc), pc4: m_pc + 32'd4});
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic check_all();
        check("imem_req", 32'(imem.imem_req), 32'(m_started && skid_q.size() == 0));
        check("imem_addr", imem.imem_addr, m_pc);
        check("if_id_valid", 32'(if_id_valid), 32'(m_valid));
        check("if_id_instr", if_id_instr, m_instr);
        check("opcode", 32'(opcode), 32'(m_instr[31:26]));
        if (m_valid) check("if_id_pc4", if_id_pc4, m_pc4);
`ifdef IF_PERF_CNT_EN
        check("perf_fetched", perf_fetched, m_fetched);
        check("perf_bubbles", perf_bubbles, m_bubbles);
`else
        check("perf_fetched", perf_fetched, 32'h0);
        check("perf_bubbles", perf_bubbles, 32'h0);
`endif
    endtask

    // One clock: model advances, DUT clocks, outputs compared 1 time unit later.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
        imem.imem_rdata = mem_word(m_pc);
    endtask

    task automatic set_in(input logic rdy, input logic st, input logic j, input logic [25:0] ji,
                          input logic b, input logic [15:0] bi);
        imem.imem_ready = rdy; stall = st; jump = j; jump_index = ji;
        branch_taken = b; branch_imm = bi;
    endtask

    initial begin
        model_reset();
        set_in(1'b1, 1'b0, 1'b0, 26'h0, 1'b0, 16'h0);
        imem.imem_rdata = mem_word(32'h0);
        #12;
        check_all();
        check("reset_instr", if_id_instr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset release, then two back-to-back fetches.
        tick();
        check("t1_addr0", imem.imem_addr, 32'h0);
        tick();
        check("t1_instr", if_id_instr, 32'h8C08_0000);
        check("t1_opcode", 32'(opcode), 32'h23);
        check("t1_pc4", if_id_pc4, 32'h4);
        check("t1_addr4", imem.imem_addr, 32'h4);

        // Three memory misses.
        set_in(1'b0, 1'b0, 1'b0, 26'h0, 1'b0, 16'h0);
        repeat (3) tick();
        check("t2_pc_hold", imem.imem_addr, 32'h4);
        check("t2_valid", 32'(if_id_valid), 32'h0);
`ifdef IF_PERF_CNT_EN
        check("t2_bubbles", perf_bubbles, 32'd3);
`endif
        set_in(1'b1, 1'b0, 1'b0, 26'h0, 1'b0, 16'h0);
        tick();
        check("t2_instr4", if_id_instr, 32'hAC09_0004);

        // Word at 0x8 returns under stall, then stall drops.
        set_in(1'b1, 1'b1, 1'b0, 26'h0, 1'b0, 16'h0);
        tick();
        check("t3_hold", if_id_instr, 32'hAC09_0004);
        check("t3_req", 32'(imem.imem_req), 32'h0);
        check("t3_pc", imem.imem_addr, 32'hC);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 26'h0, 1'b0, 16'h0);
        tick();
        check("t3_skid_instr", if_id_instr, mem_word(32'h8));
        check("t3_skid_pc4", if_id_pc4, 32'hC);

        // Jump.
        set_in(1'b1, 1'b0, 1'b1, 26'h0000040, 1'b0, 16'h0);
        tick();
        check("t4_jump_addr", imem.imem_addr, 32'h100);
        check("t4_flush", 32'(if_id_valid), 32'h0);
        set_in(1'b1, 1'b0, 1'b0, 26'h0, 1'b0, 16'h0);
        tick();

        // Branch back by one word, then jump overriding branch.
        set_in(1'b1, 1'b0, 1'b1, 26'h0000007, 1'b0, 16'h0);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 26'h0, 1'b0, 16'h0);
        tick();
        check("t5_pc4", if_id_pc4, 32'h20);
        set_in(1'b1, 1'b0, 1'b0, 26'h0, 1'b1, 16'hFFFF);
        tick();
        check("t5_branch_addr", imem.imem_addr, 32'h1C);
        set_in(1'b1, 1'b0, 1'b0, 26'h0, 1'b0, 16'h0);
        tick();
        set_in(1'b1, 1'b0, 1'b1, 26'h0000080, 1'b1, 16'hFFFF);
        tick();
        check("t5_jump_wins", imem.imem_addr, 32'h200);

        // Branch to the top word, then PC wraps to zero.
        set_in(1'b1, 1'b0, 1'b0, 26'h0, 1'b0, 16'h0);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 26'h0, 1'b1, 16'hFF7E);
        tick();
        check("wrap_target", imem.imem_addr, 32'hFFFF_FFFC);
        set_in(1'b1, 1'b0, 1'b0, 26'h0, 1'b0, 16'h0);
        tick();
        check("wrap_pc4", if_id_pc4, 32'h0);
        check("wrap_addr", imem.imem_addr, 32'h0);

        // Async reset in the middle of a skid hold.
        set_in(1'b1, 1'b1, 1'b0, 26'h0, 1'b0, 16'h0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t6_addr", imem.imem_addr, 32'h0);
        check("t6_req", 32'(imem.imem_req), 32'h0);
        check("t6_valid", 32'(if_id_valid), 32'h0);
        check("t6_instr", if_id_instr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1'b1, 1'b0, 1'b0, 26'h0, 1'b0, 16'h0);
        imem.imem_rdata = mem_word(32'h0);
        tick();
        tick();
        check("t6_after_instr", if_id_instr, 32'h8C08_0000);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            set_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) < 3),
                   1'($urandom_range(0, 19) == 0), 26'($urandom),
                   1'($urandom_range(0, 11) == 0), 16'($urandom_range(0, 63) - 32));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1);
    end

endmodule
